mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one unified, fixed-latency, single-ported memory between the pipeline's instruction-fetch port (F stage) and its data port (M stage).
- Serialises accesses, registers the read data, and returns a one-cycle ready pulse to each port.
- Drives stall requests that the hazard unit ORs into stallF and the M-stage stall.
- Both ports pending simultaneously: alternates grants, with data winning the first conflict after reset.

Parameters:
LAT, 2, memory access latency in cycles (legal 1..15; 0 illegal); address/data/write-enable held stable for LAT cycles
CW, 4, width of the internal latency counter

Ports:
clk  in  1  clock
reset  in  1  one clock; reset is asynchronous and active-low
if_req  in  1  instruction fetch request, held until if_ready
if_addr  in  32  fetch address
if_rdata  out  32  fetched instruction, valid when if_ready; held until next fetch completes
if_ready  out  1  one-cycle completion pulse, fetch port
d_req  in  1  data request, held until d_ready
d_we  in  1  1=store, 0=load
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_ready after a load
d_ready  out  1  one-cycle completion pulse, data port
stall_f  out  1  if_req & ~if_ready
stall_m  out  1  d_req & ~d_ready
mem_en  out  1  memory access active
mem_we  out  1  memory write enable (only with mem_en)
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid in last cycle of an access

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Internal registers:
  - cnt (CW bits)
  - last_gnt (0=IF, 1=D)
  - latched addr/we/wdata
- Eligibility: port eligible in IDLE iff req=1 and its ready=0 this cycle. This prevents re-accepting a request still held during its ready pulse.
- Grant in IDLE:
  - Only one port eligible: grant it.
  - Both eligible: grant D if last_gnt=0, else grant IF.
  - On grant: latch addr, we (0 for IF), wdata; cnt<=LAT-1; last_gnt<=granted port; go to BUSY_I or BUSY_D.
- BUSY_x:
  - mem_en=1; mem_addr, mem_we, mem_wdata driven from latched registers. These are unaffected by requester input changes.
  - cnt>0: cnt<=cnt-1.
  - cnt==0: capture mem_rdata into x_rdata (D port only when we=0); assert x_ready next cycle; go to IDLE.
- In IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last values.
- Timing: request first seen in IDLE cycle t → mem_en cycles t+1..t+LAT → ready high in cycle t+LAT+1 only.
  - Same port, back-to-back: accept again at t+LAT+2 earliest.
  - Other port: may be accepted in cycle t+LAT+1 itself.
- Stores take LAT cycles like loads. d_rdata is unchanged by stores. d_ready still pulses.
- Ready pulses are exactly one cycle. if_ready and d_ready are never high in the same cycle.
- if_rdata and d_rdata hold their value until overwritten by the next completion of the same port.
- Request dropped while BUSY for that port: the access completes and ready still pulses. A requester must not do this; it is not an error.
- Reset (asynchronous, any time, including mid-access) forces:
  - state=IDLE, cnt=0, last_gnt=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0
  - No ready is produced for an aborted access.
- stall_f and stall_m are purely combinational from req and ready.

Test Plan:
- LAT=2, reset released, if_req=1 with if_addr=0x00000040 from cycle 0, memory returns 0x20080005 → mem_en cycles 1-2 with mem_addr=0x40; if_ready=1 only in cycle 3 with if_rdata=0x20080005; stall_f=1 cycles 0-2.
- LAT=2, if_req and d_req (load, 0x100, memory returns 0xDEADBEEF) both asserted in cycle 0 after reset → D granted first, d_ready cycle 3 with d_rdata=0xDEADBEEF; IF accepted cycle 3, if_ready cycle 6.
- LAT=2, d_req store d_addr=0x200 d_wdata=0x12345678 → mem_we=1, mem_wdata=0x12345678 cycles 1-2; d_ready cycle 3; d_rdata unchanged from its previous value.
- LAT=2, both ports continuously requesting for 20 cycles → grants strictly alternate D, I, D, I; no port waits more than 2·(LAT+1) cycles; never both ready in one cycle.
- LAT=3, reset asserted in the second BUSY_D cycle, then released; if_req held → immediately mem_en=0, all outputs 0, no d_ready; after release IF (last_gnt=0, D not requesting) granted; if_ready after LAT+1 cycles.
- LAT=1, single port holding req across its ready pulse with a new address → new access accepted in the cycle after ready (t+LAT+2), never in the ready cycle; no duplicate access of the old address.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one unified, fixed-latency, single-ported memory between the
//   instruction-fetch port (F stage) and the data port (M stage). Accesses
//   are serialised. Read data is registered, and each port gets a one-cycle
//   ready pulse when its access completes. When both ports are pending, the
//   grant alternates between them. Data wins the first conflict after reset.
//
// Parameters
//   LAT       memory access latency in cycles (1..15)
//   CW        width of the internal latency counter
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_ready) and address
//   if_rdata/if_ready     fetched word (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata
//                         data request (held until d_ready), store flag,
//                         address and store data
//   d_rdata/d_ready       load data (held, untouched by stores) and pulse
//   stall_f/stall_m       combinational stall requests for the hazard unit
//   mem_en/mem_we/mem_addr/mem_wdata
//                         memory command; address and wdata hold when idle
//   mem_rdata             memory read data, valid in last access cycle
module mem_arbiter #(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_e;

    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_gnt_q;   // 0 = IF served last, 1 = D served last
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          mem_en_q;
    logic          mem_we_q;     // also marks a store during BUSY_D
    logic          if_ready_q;
    logic          d_ready_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

    logic          if_elig;
    logic          d_elig;
    logic          gnt_i;
    logic          gnt_d;

    // A port whose ready is pulsing this cycle still shows req high; it must
    // not be accepted again until the following cycle.
    always_comb begin
        if_elig = if_req & ~if_ready_q;
        d_elig  = d_req  & ~d_ready_q;
        gnt_d   = d_elig & (~if_elig | ~last_gnt_q);
        gnt_i   = if_elig & ~gnt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_d) begin
                        state_q    <= BUSY_D;
                        addr_q     <= d_addr;
                        wdata_q    <= d_wdata;
                        mem_we_q   <= d_we;
                        mem_en_q   <= 1'b1;
                        cnt_q      <= CNT_INIT;
                        last_gnt_q <= 1'b1;
                    end else if (gnt_i) begin
                        state_q    <= BUSY_I;
                        addr_q     <= if_addr;
                        mem_we_q   <= 1'b0;
                        mem_en_q   <= 1'b1;
                        cnt_q      <= CNT_INIT;
                        last_gnt_q <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q  <= IDLE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (state_q == BUSY_I) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_f   = if_req & ~if_ready_q;
    assign stall_m   = d_req  & ~d_ready_q;

endmodule
